// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instr} pairs; head is read straight
// from the storage registers so decode sees no extra combinational depth.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer/count bookkeeping and storage writes; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding word requests and
// buffers responses for decode.
//
// state | meaning
// IDLE  | no request; waiting for buffer credit
// REQ   | imem_req high with the current PC, waiting for gnt
// WAIT  | request granted, waiting for its rvalid to push
// DROP  | a redirect made the in-flight response stale; swallow it
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            push, pop, flush;
  logic [CW-1:0]   count;
  logic            empty, full;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            in_flight;
  logic [CW:0]     occupancy;
  logic [CW:0]     post_count;
  logic            credit;

  assign in_flight  = (state_q == WAIT) || (state_q == DROP);
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, in_flight};
  assign credit     = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign post_count = {1'b0, count} + (CW + 1)'(1) - {{CW{1'b0}}, pop};
  assign push_data  = '{pc: req_pc_q, instr: imem_rdata};

  assign imem_addr  = pc_q;
  assign inst_valid = !empty;
  assign inst_o     = empty ? NOP_INSTR : head.instr;
  assign inst_pc    = empty ? '0 : head.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  // State, fetch PC and the PC of the granted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state and handshake outputs; a redirect overrides everything else.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    imem_req = 1'b0;
    pop      = inst_valid && inst_ready && !redirect_valid;

    unique case (state_q)
      IDLE: if (credit) state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = (post_count < (CW + 1)'(FIFO_DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_gnt ? DROP : REQ;
        // A response arriving with the redirect is the stale one itself.
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

endmodule
